uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between N byte-stream requesters, e.g. UART echo path, flash/SPI status reporter and debug/LED status.
- Grants the transmitter one packet at a time, round-robin.
- Frames each packet as: header byte (channel ID), payload bytes, trailer byte (payload count).
- Sits between the requesters and the uart's tx_data/tx_data_valid/tx_data_ready port, in the clk_48 domain.

Parameters:
- N, 4, number of requesters (1..16).
- MAX_LEN, 255, maximum payload bytes per packet (1..255); the packet is closed forcibly when reached.
- HDR_TAG, 4'hA, upper nibble of the header byte.

Ports:
- clk_48  in  1  system clock (48 MHz).
- rst  in  1  synchronous reset, active-high.
- req_data  in  8*N  payload byte per requester; channel i occupies bits [8i+7:8i].
- req_valid  in  N  requester i has a byte on req_data.
- req_last  in  N  byte from requester i is the last of its packet.
- req_ready  out  N  byte from requester i accepted this cycle (when req_valid also high).
- grant  out  N  one-hot packet owner; all zero when idle.
- tx_data  out  8  byte to the uart.
- tx_data_valid  out  1  tx_data is valid.
- tx_data_ready  in  1  uart accepts tx_data this cycle.
- busy  out  1  a packet is in progress or the output register is occupied.

Behaviour:
- Clocking and reset: one clock, clk_48. rst is synchronous and active-high, sampled on the rising edge of clk_48.
- Reset values: state=IDLE, grant=0, req_ready=0, tx_data_valid=0, tx_data=8'h00, rr pointer=N-1 (channel 0 is highest priority first), payload count=0, busy=0.
- Output register: a single byte. Let "free" = !tx_data_valid || tx_data_ready.
  - A byte leaves when tx_data_valid && tx_data_ready.
  - A new byte may load in that same cycle.
  - tx_data is stable while tx_data_valid=1 && tx_data_ready=0.
- States: IDLE, PAYLOAD, TRAILER.
- IDLE:
  - req_ready=0.
  - If free and any req_valid: pick the first asserted channel g, searching from rr+1 mod N upward with wrap.
  - On that edge: load tx_data={HDR_TAG, g[3:0]}, tx_data_valid=1, grant=onehot(g), rr=g, count=0, go to PAYLOAD.
  - The header appears 1 cycle after req_valid is seen.
- PAYLOAD:
  - req_ready[g] = free; other bits of req_ready are 0.
  - Transfer = req_valid[g] && req_ready[g]. On transfer: tx_data=req_data[g], tx_data_valid=1, count=count+1.
  - If req_last[g] is high, or the new count equals MAX_LEN: go to TRAILER.
  - Non-granted requesters are ignored (held off) until the packet ends.
  - If req_valid[g] is low, the state holds; there is no timeout.
- TRAILER:
  - req_ready=0.
  - When free: load tx_data=count (8-bit), tx_data_valid=1, grant=0, go to IDLE.
- Forced close: at MAX_LEN the trailer carries MAX_LEN. The requester's further bytes are not lost; they start a new packet under a later grant.
- Byte sequencing:
  - A byte accepted from a requester reaches tx_data the next cycle.
  - The header or trailer load in the same cycle the previous byte drains, so there are no bubbles when the uart is always ready.
- busy = (state != IDLE) || tx_data_valid.
- Simultaneous events:
  - An IDLE arbitration may coincide with the trailer byte draining.
  - A requester raising req_valid in the grant cycle is arbitrated in the next IDLE only.
- Mid-operation reset: everything returns to reset values in the same edge. A partial packet is truncated; the byte in the output register is discarded.
- Width rule: count is 8 bits. It cannot wrap because MAX_LEN ≤ 255.

Test Plan:
- Single packet: rst then idle, tx_data_ready=1; ch1 sends 8'h11, 8'h22, 8'h33(last) → uart sees A1, 11, 22, 33, 03. grant=0010 during the packet; busy drops after 03 drains.
- Round-robin: ch0 and ch2 both valid with 1-byte packets, repeated → order ch0, ch2, ch0, ch2; headers A0, A2, A0, A2. The trailer after each single payload byte is 01.
- Backpressure: tx_data_ready toggles 1,0,0,1 during a packet → tx_data is held stable while not ready. No byte is dropped or duplicated; req_ready[g] is low whenever the register is full and not draining.
- MAX_LEN=3 with ch3 streaming 5 bytes, last on the 5th → A3, b1, b2, b3, 03, A3, b4, b5, 02.
- Reset mid-packet: assert rst after the 2nd payload byte → next cycle tx_data_valid=0, grant=0, req_ready=0. A subsequent ch0 request gets header A0, because rr resets to N-1.
- Back-to-back, always ready: ch0 2-byte packet followed immediately by ch1 packet → contiguous stream A0, x, y, 02, A1, ... with tx_data_valid continuously high.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N byte-stream requesters. Packets are
//   granted round-robin, one at a time, and framed on the way out as
//   header {HDR_TAG, channel}, payload bytes, trailer (payload count).
//
// Ports
//   clk_48         system clock
//   rst            synchronous reset, active-high
//   req_data       payload byte per requester, channel i at [8i+7:8i]
//   req_valid      requester i presents a byte
//   req_last       byte from requester i closes its packet
//   req_ready      byte from requester i accepted this cycle
//   grant          one-hot packet owner, zero when idle
//   tx_data        byte to the uart
//   tx_data_valid  tx_data holds a byte
//   tx_data_ready  uart takes tx_data this cycle
//   busy           packet in progress or output register occupied
module uart_tx_arbiter #(
  parameter int         N       = 4,
  parameter int         MAX_LEN = 255,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic           clk_48,
  input  logic           rst,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  output logic [7:0]     tx_data,
  output logic           tx_data_valid,
  input  logic           tx_data_ready,
  output logic           busy
);

  localparam int              IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0]      MAX_B  = 8'(MAX_LEN);
  localparam logic [IW-1:0]   RR_RST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_vld_q, tx_vld_d;

  logic          free;
  logic          found;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic [7:0]    cnt_inc;
  logic [7:0]    cur_data;
  logic          cur_last;
  logic          xfer;

  // Round-robin search: first valid channel starting just after the last
  // owner, wrapping. rr_q doubles as the owner index while a packet runs.
  always_comb begin
    found = 1'b0;
    sel   = rr_q;
    idx   = rr_q;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(rr_q) + k) % N);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Payload byte and last flag of the current owner.
  always_comb begin
    cur_data = 8'h00;
    cur_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rr_q == IW'(i)) begin
        cur_data = req_data[8*i +: 8];
        cur_last = req_last[i];
      end
    end
  end

  // The output register can take a new byte when empty or draining now.
  assign free    = !tx_vld_q || tx_data_ready;
  assign cnt_inc = cnt_q + 8'd1;
  assign xfer    = (state_q == PAYLOAD) && free && req_valid[rr_q];

  always_comb begin
    req_ready = '0;
    if (state_q == PAYLOAD) begin
      req_ready[rr_q] = free;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q && !tx_data_ready;
    case (state_q)
      IDLE: begin
        if (free && found) begin
          tx_data_d    = {HDR_TAG, 4'(sel)};
          tx_vld_d     = 1'b1;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          rr_d         = sel;
          cnt_d        = 8'd0;
          state_d      = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          tx_data_d = cur_data;
          tx_vld_d  = 1'b1;
          cnt_d     = cnt_inc;
          // Forced close at MAX_LEN; remaining bytes go in a later packet.
          if (cur_last || (cnt_inc == MAX_B)) begin
            state_d = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (free) begin
          tx_data_d = cnt_q;
          tx_vld_d  = 1'b1;
          grant_d   = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_48) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= RR_RST;
      cnt_q     <= 8'd0;
      tx_data_q <= 8'h00;
      tx_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
    end
  end

  assign grant         = grant_q;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_vld_q;
  assign busy          = (state_q != IDLE) || tx_vld_q;

endmodule
